// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the radix-4 Booth multiplier slice:
//   - state_t   : control FSM states (ST_IDLE, ST_RUN)
//   - pp_sel_t  : partial-product selection decoded from one Booth group
//   - GROUP_BITS / BITS_PER_ITER : Booth group width and multiplier bits retired per step
//   - n_iter()  : iteration count for a given operand width
// -----------------------------------------------------------------------------
package booth_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Overlapping 3-bit window of the multiplier, two new bits consumed per iteration
  localparam int GROUP_BITS    = 3;
  localparam int BITS_PER_ITER = 2;

  typedef enum logic [2:0] {
    PP_ZERO = 3'd0,
    PP_POS1 = 3'd1,
    PP_POS2 = 3'd2,
    PP_NEG2 = 3'd3,
    PP_NEG1 = 3'd4
  } pp_sel_t;

  // Operands are widened by two bits so signed and unsigned share one datapath;
  // each iteration retires two bits of that widened multiplier.
  function automatic int n_iter(input int width);
    return (width + 2) / BITS_PER_ITER;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// -----------------------------------------------------------------------------
// booth_r4_encoder
// Purely combinational radix-4 Booth recoder for one 3-bit multiplier group.
// Ports:
//   i_group : {q[i+1], q[i], q[i-1]} window of the multiplier
//   o_zero  : partial product is zero
//   o_two   : partial product magnitude is 2*M (else 1*M)
//   o_neg   : partial product is negated (never set together with o_zero)
// -----------------------------------------------------------------------------
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [GROUP_BITS-1:0] i_group,
  output logic                  o_zero,
  output logic                  o_two,
  output logic                  o_neg
);

  pp_sel_t w_sel;

  // Map the group onto one of the five Booth digits {0, +1, +2, -2, -1}
  always_comb begin
    w_sel = PP_ZERO;
    case (i_group)
      3'b001, 3'b010: w_sel = PP_POS1;
      3'b011:         w_sel = PP_POS2;
      3'b100:         w_sel = PP_NEG2;
      3'b101, 3'b110: w_sel = PP_NEG1;
      default:        w_sel = PP_ZERO;
    endcase
  end

  assign o_zero = (w_sel == PP_ZERO);
  assign o_two  = (w_sel == PP_POS2) || (w_sel == PP_NEG2);
  assign o_neg  = (w_sel == PP_NEG2) || (w_sel == PP_NEG1);

endmodule

// File: rtl/booth_r4_mult.sv
// -----------------------------------------------------------------------------
// booth_r4_mult
// Sequential radix-4 Booth multiplier, one add+shift iteration per clock.
// Operands are extended to WIDTH+2 bits (sign- or zero-extended per is_signed)
// so the same datapath serves both signed and unsigned operations.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous reset, active-high, overrides start
//   start      : request, accepted only when idle
//   is_signed  : 1 = two's-complement operands, sampled with start
//   a, b       : multiplicand / multiplier, sampled with start
//   accumulate : (BOOTH_MAC_EN only) add product onto p instead of replacing it
//   busy       : high while an operation runs
//   done       : one-cycle pulse when p has been updated
//   p          : 2*WIDTH-bit product, held until the next completion
// Configuration macro: BOOTH_MAC_EN adds the accumulate port and p += product.
// -----------------------------------------------------------------------------
module booth_r4_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef BOOTH_MAC_EN
  input  logic               accumulate,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int XW = WIDTH + 2;
  localparam int AW = XW + 2;
  localparam int PW = 2 * WIDTH;
  localparam int N  = n_iter(WIDTH);
  localparam int CW = $clog2(N + 1);

  state_t          r_state;
  logic [AW-1:0]   r_a;
  logic [XW:0]     r_q;
  logic [AW-1:0]   r_m;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [PW-1:0]   r_p;
`ifdef BOOTH_MAC_EN
  logic            r_acc;
`endif

  logic [XW-1:0]   w_aExt;
  logic [XW-1:0]   w_bExt;
  logic            w_zero;
  logic            w_two;
  logic            w_neg;
  logic [AW-1:0]   w_mult;
  logic [AW-1:0]   w_pp;
  logic [AW-1:0]   w_operand;
  logic [AW-1:0]   w_sum;
  logic [AW-1:0]   w_newA;
  logic [XW:0]     w_newQ;
  logic [PW-1:0]   w_prod;

  assign w_aExt = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
  assign w_bExt = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

  booth_r4_encoder u_encoder (
    .i_group (r_q[GROUP_BITS-1:0]),
    .o_zero  (w_zero),
    .o_two   (w_two),
    .o_neg   (w_neg)
  );

  // Subtraction is done as invert plus carry-in so only one adder is needed
  assign w_mult    = w_two ? {r_m[AW-2:0], 1'b0} : r_m;
  assign w_pp      = w_zero ? '0 : w_mult;
  assign w_operand = w_neg ? ~w_pp : w_pp;
  assign w_sum     = r_a + w_operand + {{(AW-1){1'b0}}, w_neg};

  // Arithmetic right shift of {S,Q} by two in the same cycle as the add
  assign w_newA = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
  assign w_newQ = {w_sum[1:0], r_q[XW:2]};
  assign w_prod = PW'({w_newA, w_newQ[XW:1]});

  // Control FSM and datapath registers: load operands on start, iterate N times,
  // then publish the product and pulse done for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_p     <= '0;
`ifdef BOOTH_MAC_EN
      r_acc   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= '0;
            r_q     <= {w_bExt, 1'b0};
            r_m     <= {{2{w_aExt[XW-1]}}, w_aExt};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
`ifdef BOOTH_MAC_EN
            r_acc   <= accumulate;
`endif
          end
        end
        ST_RUN: begin
          r_a   <= w_newA;
          r_q   <= w_newQ;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
`ifdef BOOTH_MAC_EN
            r_p <= r_acc ? (r_p + w_prod) : w_prod;
`else
            r_p <= w_prod;
`endif
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign p    = r_p;

endmodule

// File: tb/tb_booth_r4_mult.sv
// -----------------------------------------------------------------------------
// tb_booth_r4_mult
// Directed bench for booth_r4_mult (WIDTH=8). Stimulus pushes the expected
// product and issue cycle into a scoreboard; a monitor pops on every done pulse
// and checks the product and the start-to-done latency.
// With BOOTH_MAC_EN defined the accumulate port is connected and MAC cases run.
// -----------------------------------------------------------------------------
module tb_booth_r4_mult;

  localparam int WIDTH = 8;
  localparam int NITER = WIDTH / 2 + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              isSigned;
  logic              accumulate;
  logic [WIDTH-1:0]  opA;
  logic [WIDTH-1:0]  opB;
  logic              busy;
  logic              done;
  logic [2*WIDTH-1:0] p;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  logic [2*WIDTH-1:0] expQ[$];
  int                 cycQ[$];
  string              nameQ[$];

  booth_r4_mult #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (isSigned),
    .a          (opA),
    .b          (opB),
`ifdef BOOTH_MAC_EN
    .accumulate (accumulate),
`endif
    .busy       (busy),
    .done       (done),
    .p          (p)
  );

  // Free-running clock and cycle counter used to measure latency
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, required);
    end
  endtask

  // Drive one request for a single clock; call with the clock low
  task automatic applyStimulus(input logic sgn, input logic acc, input logic [WIDTH-1:0] x,
                               input logic [WIDTH-1:0] y, input logic [2*WIDTH-1:0] expP,
                               input string name);
    start      = 1'b1;
    isSigned   = sgn;
    accumulate = acc;
    opA        = x;
    opB        = y;
    $display("[TB] issue %s a=%h b=%h signed=%0b acc=%0b", name, x, y, sgn, acc);
    @(posedge clk);
    #1;
    expQ.push_back(expP);
    cycQ.push_back(cycle);
    nameQ.push_back(name);
    start = 1'b0;
  endtask

  // Returns at the falling edge of the done cycle, or flags a timeout
  task automatic waitDone(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("done_timeout", {31'd0, seen}, 32'd1);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    logic [2*WIDTH-1:0] e;
    int                 c;
    string              nm;
    if (done) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: got done with p=%h required no done", p);
      end else begin
        e  = expQ.pop_front();
        c  = cycQ.pop_front();
        nm = nameQ.pop_front();
        checkOutput(nm, {16'd0, p}, {16'd0, e});
        checkOutput({nm, "_latency"}, cycle - c, NITER);
      end
    end
  end

  initial begin
    int doneCount;
    rst        = 1'b1;
    start      = 1'b0;
    isSigned   = 1'b0;
    accumulate = 1'b0;
    opA        = '0;
    opB        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_p", {16'd0, p}, 32'd0);

    // Basic signed/unsigned vectors, hand-computed
    applyStimulus(1'b1, 1'b0, 8'd13, 8'd28, 16'h016C, "s_13x28");
    checkOutput("busy_running", {31'd0, busy}, 32'd1);
    waitDone(20);
    checkOutput("busy_in_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'h80, 8'h80, 16'h4000, "s_m128xm128");
    waitDone(20);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'hFF, 8'h7F, 16'hFF81, "s_m1x127");
    waitDone(20);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_255x255");
    waitDone(20);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'hFF, 8'hFF, 16'h0001, "s_m1xm1");
    waitDone(20);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'h80, 8'h7F, 16'hC080, "s_m128x127");
    waitDone(20);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 8'h80, 8'h02, 16'h0100, "u_128x2");
    waitDone(20);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h55, 16'h0000, "u_0x85");
    waitDone(20);

    // start and operand changes while busy must be ignored
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'd6, 8'd7, 16'h002A, "ignore_first");
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    opA   = 8'd9;
    opB   = 8'd9;
    @(negedge clk);
    start = 1'b0;
    opA   = 8'd3;
    checkOutput("busy_after_ignored_start", {31'd0, busy}, 32'd1);
    waitDone(20);
    repeat (8) @(negedge clk);

    // Back-to-back: start held in the done cycle is accepted
    applyStimulus(1'b0, 1'b0, 8'd3, 8'd4, 16'h000C, "b2b_first");
    waitDone(20);
    applyStimulus(1'b0, 1'b0, 8'd10, 8'd10, 16'h0064, "b2b_second");
    waitDone(20);

    // Reset in the middle of RUN aborts the operation and clears p
    @(negedge clk);
    start    = 1'b1;
    isSigned = 1'b0;
    opA      = 8'd5;
    opB      = 8'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    checkOutput("midrst_p", {16'd0, p}, 32'd0);
    doneCount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("midrst_no_done", doneCount, 32'd0);

    // Recovery after abort
    applyStimulus(1'b1, 1'b0, 8'h7F, 8'h7F, 16'h3F01, "s_127x127");
    waitDone(20);

`ifdef BOOTH_MAC_EN
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 8'd3, 8'd4, 16'd12, "mac_load");
    waitDone(20);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 8'd5, 8'd6, 16'd42, "mac_accumulate");
    waitDone(20);
`endif

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
